// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter.
package uart_pkg;

    // Payload bits per frame, and total bits per frame (start + data + stop).
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Serialiser phase within one frame.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// Transmit-only UART serialiser: 8 data bits, no parity, 1 stop bit, LSB
// first, idle-high line. A send seen while idle starts one frame; done
// pulses for exactly the last cycle of the stop bit, so a sequencer that
// answers done with its next send gets back-to-back frames separated by a
// single idle-high cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       send,
    input  logic [7:0] byte_to_send,
    output logic       done,
    output logic       pin
);

    // Baud counter runs 0..clocks_per_bit-1 inside every serial bit.
    localparam int CW = $clog2(clocks_per_bit + 1);

    // Last count of a bit period.
    localparam logic [CW-1:0] LAST_COUNT = CW'(clocks_per_bit - 1);

    // Count one before the last. done is registered, so it has to be
    // raised from here to line up with the final stop-bit cycle. Only
    // meaningful when a bit spans two or more cycles.
    localparam logic [CW-1:0] PRE_LAST_COUNT =
        CW'((clocks_per_bit > 1) ? clocks_per_bit - 2 : 0);

    // With one cycle per bit the stop bit is a single cycle, so done is
    // raised while leaving DATA instead.
    localparam logic SINGLE_CYCLE_BIT = (clocks_per_bit == 1);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t     state;
    logic [CW-1:0]   cycle_count;
    logic [2:0]      bit_index;
    logic [7:0]      shift_reg;

    // Frame sequencer: state, baud counter, bit index, shift register and
    // the registered line/done outputs all advance together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the shift register is reset along with the control
            // state so a mid-frame abort leaves no stale data behind.
            state       <= IDLE;
            pin         <= 1'b1;
            done        <= 1'b0;
            bit_index   <= '0;
            cycle_count <= '0;
            shift_reg   <= '0;
        end else begin
            // NOTE: every assignment here is non-blocking, so each branch
            // below reads the values from before this edge.
            done <= 1'b0;

            case (state)
                IDLE: begin
                    pin         <= 1'b1;
                    cycle_count <= '0;
                    bit_index   <= '0;
                    if (send) begin
                        shift_reg <= byte_to_send;
                        pin       <= 1'b0;
                        state     <= START;
                    end
                end

                START: begin
                    if (cycle_count == LAST_COUNT) begin
                        cycle_count <= '0;
                        pin         <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                        state       <= DATA;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end

                DATA: begin
                    if (cycle_count == LAST_COUNT) begin
                        cycle_count <= '0;
                        if (bit_index == LAST_BIT) begin
                            pin   <= 1'b1;
                            done  <= SINGLE_CYCLE_BIT;
                            state <= STOP;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                            pin       <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end

                STOP: begin
                    if (cycle_count == LAST_COUNT) begin
                        cycle_count <= '0;
                        bit_index   <= '0;
                        state       <= IDLE;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                        done        <= (cycle_count == PRE_LAST_COUNT);
                    end
                end

                default: begin
                    pin   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. Three instances (4, 1 and 2 cycles per bit) share clock
// and reset. Each one has a frame-level reference: when a send is accepted
// on an idle line the whole expected waveform (start, 8 data bits LSB first,
// stop, done on the last cycle) is appended to a queue, and the line and
// done are compared against the head of that queue every cycle.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int N = 3;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       send    [N];
    logic [7:0] byte_in [N];
    logic       pin     [N];
    logic       done    [N];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    for (genvar g = 0; g < N; g++) begin : lane
        localparam int C = (g == 0) ? 4 : (g == 1) ? 1 : 2;

        uart_tx #(.clocks_per_bit(C)) dut (
            .clock        (clock),
            .reset_n      (reset_n),
            .send         (send[g]),
            .byte_to_send (byte_in[g]),
            .done         (done[g]),
            .pin          (pin[g])
        );

        logic exp_pin  [$];
        logic exp_done [$];
        int   done_cnt = 0;

        // Reference: consume one expected cycle per edge; an idle cycle with
        // send high schedules a complete frame built from the byte seen then.
        always @(posedge clock or negedge reset_n) begin
            logic was_idle;
            logic v;
            if (!reset_n) begin
                exp_pin.delete();
                exp_done.delete();
            end else begin
                was_idle = (exp_pin.size() == 0);
                if (!was_idle) begin
                    void'(exp_pin.pop_front());
                    void'(exp_done.pop_front());
                end
                if (was_idle && send[g]) begin
                    for (int b = 0; b < FRAME_BITS; b++) begin
                        if (b == 0) v = 1'b0;
                        else if (b == FRAME_BITS - 1) v = 1'b1;
                        else v = byte_in[g][b-1];
                        for (int c = 0; c < C; c++) begin
                            exp_pin.push_back(v);
                            exp_done.push_back((b == FRAME_BITS - 1) && (c == C - 1));
                        end
                    end
                end
            end
        end

        // Per-cycle comparison, away from the active edge.
        always @(negedge clock) begin
            check($sformatf("pin%0d", g), 32'(pin[g]),
                  32'((exp_pin.size() != 0) ? exp_pin[0] : 1'b1));
            check($sformatf("done%0d", g), 32'(done[g]),
                  32'((exp_done.size() != 0) ? exp_done[0] : 1'b0));
            if (done[g] === 1'b1) done_cnt++;
        end
    end

    function automatic int cpb_of(input int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : 2;
    endfunction

    // Pulse send for one cycle with byte b; returns in frame cycle 1.
    task automatic send_byte(input int g, input logic [7:0] b);
        @(negedge clock);
        send[g]    = 1'b1;
        byte_in[g] = b;
        @(negedge clock);
        send[g]    = 1'b0;
        byte_in[g] = 8'($urandom);
    endtask

    // Wait (bounded) until done is seen; returns cycles waited.
    task automatic wait_done(input int g, output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (done[g] !== 1'b1 && cycles < 400);
        check($sformatf("done_seen%0d", g), 32'(done[g]), 32'd1);
    endtask

    initial begin
        int cyc;
        int d0;
        logic [7:0] seq_bytes [5];

        for (int g = 0; g < N; g++) begin
            send[g]    = 1'b0;
            byte_in[g] = 8'h00;
        end

        // Reset held: toggle inputs, line must stay idle with no done.
        repeat (6) begin
            @(negedge clock);
            for (int g = 0; g < N; g++) begin
                send[g]    = 1'($urandom);
                byte_in[g] = 8'($urandom);
            end
        end
        @(negedge clock);
        for (int g = 0; g < N; g++) send[g] = 1'b0;
        check("reset_pin0", 32'(pin[0]), 32'd1);
        check("reset_done0", 32'(done[0]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Single byte A5 at 4 cycles per bit: done lands on frame cycle 40.
        send_byte(0, 8'hA5);
        wait_done(0, cyc);
        check("a5_frame_len", 32'(cyc + 1), 32'(FRAME_BITS * cpb_of(0)));
        @(negedge clock);
        check("a5_done_width", 32'(done[0]), 32'd0);

        // One cycle per bit: FF then 00 issued on done.
        d0 = lane[1].done_cnt;
        send_byte(1, 8'hFF);
        wait_done(1, cyc);
        check("ff_frame_len", 32'(cyc + 1), 32'(FRAME_BITS));
        send_byte(1, 8'h00);
        wait_done(1, cyc);
        check("00_frame_len", 32'(cyc + 1), 32'(FRAME_BITS));
        repeat (4) @(negedge clock);
        check("cpb1_done_count", 32'(lane[1].done_cnt - d0), 32'd2);

        // Busy-ignore: send 81 during DATA of a 3C frame.
        d0 = lane[0].done_cnt;
        send_byte(0, 8'h3C);
        repeat (10) @(negedge clock);
        send_byte(0, 8'h81);
        wait_done(0, cyc);
        repeat (60) @(negedge clock);
        check("busy_done_count", 32'(lane[0].done_cnt - d0), 32'd1);

        // Sequencer emulation at 2 cycles per bit.
        seq_bytes = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'hFE};
        d0 = lane[2].done_cnt;
        send_byte(2, seq_bytes[0]);
        for (int i = 1; i < 5; i++) begin
            wait_done(2, cyc);
            send_byte(2, seq_bytes[i]);
        end
        wait_done(2, cyc);
        repeat (30) @(negedge clock);
        check("seq_done_count", 32'(lane[2].done_cnt - d0), 32'd5);

        // send held high, byte changed mid-frame and between frames.
        d0 = lane[1].done_cnt;
        @(negedge clock);
        send[1]    = 1'b1;
        byte_in[1] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            repeat (4) @(negedge clock);
            byte_in[1] = 8'($urandom);
            wait_done(1, cyc);
            if (i == 5) send[1] = 1'b0;
            else byte_in[1] = 8'($urandom);
        end
        repeat (20) @(negedge clock);
        check("held_done_count", 32'(lane[1].done_cnt - d0), 32'd6);

        // Reset mid-DATA: line high at once, no done afterwards.
        d0 = lane[2].done_cnt;
        send_byte(2, 8'h5A);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("abort_pin", 32'(pin[2]), 32'd1);
        check("abort_done", 32'(done[2]), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        check("abort_no_done", 32'(lane[2].done_cnt - d0), 32'd0);

        // Random traffic on all lanes.
        repeat (600) begin
            @(negedge clock);
            for (int g = 0; g < N; g++) begin
                send[g]    = ($urandom_range(0, 3) == 0);
                byte_in[g] = 8'($urandom);
            end
        end
        @(negedge clock);
        for (int g = 0; g < N; g++) send[g] = 1'b0;
        repeat (60) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
